bot_updt_responder: RTL
=======================

BOT_UPDT_RESPONDER -- requirements
Module: bot_updt_responder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of BotInfo snapshot entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter ACK_HOLD, default 2, meaning the number of clk cycles o_int_ack stays high per acknowledge; legal range is 1 to 15.
REQ-003 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning the number of clk cycles to wait for the synchronized update flag to fall before re-acknowledging.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port i_botupdt_sync, input, 1 bit: sticky update flag from the handshake flip-flop, which is asynchronous to clk.
REQ-007 The block SHALL have port i_botinfo, input, 32 bits: {LocX[31:24], LocY[23:16], Sensors[15:8], BotInfo[7:0]}, stable while i_botupdt_sync is high.
REQ-008 The block SHALL have port o_int_ack, output, 1 bit: the acknowledge that clears the handshake flip-flop.
REQ-009 The block SHALL have port i_pop, input, 1 bit: CPU-side pop of the FIFO head.
REQ-010 The block SHALL have port o_rdata, output, 32 bits: the FIFO head entry in first-word-fall-through mode.
REQ-011 The block SHALL have port o_empty, output, 1 bit, and port o_full, output, 1 bit: the FIFO status flags.
REQ-012 The block SHALL have port o_count, output, $clog2(FIFO_DEPTH)+1 bits: the current number of FIFO entries.
REQ-013 The block SHALL have port o_overflow, output, 1 bit: sticky flag meaning a snapshot was dropped.
REQ-014 The block SHALL have port o_timeout, output, 1 bit: sticky flag meaning an acknowledge was retried.
REQ-015 The block SHALL have port i_clr_err, input, 1 bit: a one-cycle pulse that clears o_overflow and o_timeout.
REQ-016 The block SHALL have port o_irq, output, 1 bit: registered, equal to !o_empty.

Function
REQ-017 The block SHALL pass i_botupdt_sync through a 2-flop synchronizer; the FSM uses only the synchronized value (sync_q).
REQ-018 The FSM SHALL have states IDLE, CAPTURE, ACK, and WAIT_LOW.
REQ-019 In IDLE, when sync_q is 1, the FSM SHALL move to CAPTURE on the next clk edge.
REQ-020 In CAPTURE, the block SHALL register i_botinfo and push it into the FIFO, then move to ACK after exactly 1 cycle.
REQ-021 In ACK, o_int_ack SHALL be 1 for exactly ACK_HOLD cycles, after which the FSM moves to WAIT_LOW.
REQ-022 In WAIT_LOW, when sync_q is 0, the FSM SHALL move to IDLE; if sync_q is still 1 after ACK_TIMEOUT cycles, the block SHALL set o_timeout and return to ACK without pushing.
REQ-023 o_int_ack SHALL be a registered output and SHALL be 0 in every state other than ACK.
REQ-024 Latency SHALL be as follows: i_botupdt_sync rises before edge N; sync_q is 1 at N+2; CAPTURE is at N+3; o_int_ack is high from N+4 to N+3+ACK_HOLD.
REQ-025 A push while the FIFO is full and no pop occurs in the same cycle SHALL discard the new snapshot, set o_overflow, and still complete the acknowledge.
REQ-026 On a simultaneous push and pop, both SHALL take effect, o_count SHALL be unchanged, and this holds even when the FIFO is full.
REQ-027 A pop while the FIFO is empty SHALL be ignored and SHALL NOT underflow o_count.
REQ-028 o_rdata SHALL present the head entry whenever !o_empty, SHALL be 32'h0 when empty, and SHALL update the cycle after a pop.
REQ-029 FIFO pointers SHALL be $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH; o_count SHALL range from 0 to FIFO_DEPTH.
REQ-030 i_clr_err SHALL clear both sticky flags, and a set event in the same cycle as the clear SHALL win.
REQ-031 A sync_q pulse shorter than the time to reach CAPTURE SHALL still result in exactly one capture, because the state is reached once sync_q is sampled as 1.

Reset
REQ-032 When rst is asserted, the block SHALL asynchronously force the FSM to IDLE, clear the synchronizer, and zero the FIFO pointers and count.
REQ-033 While rst is asserted, the outputs SHALL be o_int_ack=0, o_empty=1, o_full=0, o_count=0, o_rdata=0, o_overflow=0, o_timeout=0, o_irq=0.
REQ-034 Reset asserted mid-handshake SHALL abandon the handshake; after release, a still-high i_botupdt_sync SHALL be treated as a new update.

Structure
REQ-035 Package bot_updt_pkg SHALL hold the FSM state enum, the BotInfo field offsets (LOCX_MSB=31 ... BOTINFO_LSB=0), and the default parameter constants.
REQ-036 Sub-module botinfo_fifo SHALL be parameterized by FIFO_DEPTH, provide first-word-fall-through behaviour, and contain the pointers, count, and full/empty logic.

Verification
REQ-037 Directed test, single update: i_botinfo=32'h1A2B0305, sync rises at cycle 10 -> o_int_ack is high at cycles 14-15, o_rdata=32'h1A2B0305, o_count=1, o_irq=1.
REQ-038 Directed test, overflow: 5 updates with no pop -> after the 5th, o_full=1, o_overflow=1, o_count=4, o_rdata equals the 1st snapshot, and all 5 updates are acknowledged.
REQ-039 Directed test, wrap: 6 push/pop pairs -> the entries are read in order, and o_count returns to 0 with o_empty=1.
REQ-040 Directed test, timeout: sync is held high for 300 cycles -> o_timeout=1, o_int_ack re-pulses after 255 WAIT_LOW cycles, and only one push occurs.
REQ-041 Directed test, simultaneous push and pop when full: count stays 4, the head advances, and o_overflow stays 0.
REQ-042 Directed test, reset mid-ACK: rst is asserted during o_int_ack high -> all outputs match REQ-033 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/bot_updt_pkg.sv
// Shared types and constants for the BotInfo update responder:
// FSM states, BotInfo word field offsets and default parameter values.
package bot_updt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_ACK      = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_e;

  localparam int LOCX_MSB    = 31;
  localparam int LOCX_LSB    = 24;
  localparam int LOCY_MSB    = 23;
  localparam int LOCY_LSB    = 16;
  localparam int SENSORS_MSB = 15;
  localparam int SENSORS_LSB = 8;
  localparam int BOTINFO_MSB = 7;
  localparam int BOTINFO_LSB = 0;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_ACK_HOLD    = 2;
  localparam int DEF_ACK_TIMEOUT = 255;

endpackage

// File: rtl/botinfo_fifo.sv
// First-word-fall-through snapshot FIFO. A push into a full FIFO is accepted
// only when a pop frees the head in the same cycle; otherwise it is dropped.
module botinfo_fifo
  import bot_updt_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [31:0]                   wdata_i,
  input  logic                          pop_i,
  output logic [31:0]                   rdata_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          irq_o,
  output logic                          drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ZERO_CNT = (AW+1)'(0);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          irq_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_pop_s  = pop_i && (count_q != ZERO_CNT);
  assign do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);
  assign drop_o    = push_i && !do_push_s;

  always_comb begin
    count_d = count_q;
    if (do_push_s && !do_pop_s) begin
      count_d = count_q + ONE_CNT;
    end else if (do_pop_s && !do_push_s) begin
      count_d = count_q - ONE_CNT;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= ZERO_CNT;
      irq_q    <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      irq_q   <= (count_d != ZERO_CNT);
    end
  end

  // Storage needs no reset: the read port is gated by the empty condition.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = (count_q == ZERO_CNT) ? 32'h0000_0000 : mem_q[rd_ptr_q];
  assign empty_o = (count_q == ZERO_CNT);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign irq_o   = irq_q;

endmodule

// File: rtl/bot_updt_responder.sv
// Responds to the asynchronous BotInfo update flag: synchronizes it, snapshots
// the BotInfo word into a FIFO, and pulses the acknowledge that clears the flag.
module bot_updt_responder
  import bot_updt_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int ACK_HOLD    = DEF_ACK_HOLD,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_botupdt_sync,
  input  logic [31:0]                   i_botinfo,
  output logic                          o_int_ack,
  input  logic                          i_pop,
  output logic [31:0]                   o_rdata,
  output logic                          o_empty,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_overflow,
  output logic                          o_timeout,
  input  logic                          i_clr_err,
  output logic                          o_irq
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [3:0]    HOLD_LAST = 4'(ACK_HOLD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

  state_e        state_q;
  logic          sync_meta_q;
  logic          sync_q;
  logic [3:0]    hold_cnt_q;
  logic [TW-1:0] tmo_cnt_q;
  logic          ack_q;
  logic          overflow_q;
  logic          timeout_q;
  logic          push_s;
  logic          drop_s;
  logic          retry_s;

  assign push_s  = (state_q == ST_CAPTURE);
  assign retry_s = (state_q == ST_WAIT_LOW) && sync_q && (tmo_cnt_q == TMO_LAST);

  // The acknowledge is raised on the same edge that enters ACK so it tracks the state exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= ST_IDLE;
      hold_cnt_q  <= 4'd0;
      tmo_cnt_q   <= TW'(0);
      ack_q       <= 1'b0;
    end else begin
      sync_meta_q <= i_botupdt_sync;
      sync_q      <= sync_meta_q;
      case (state_q)
        ST_IDLE: begin
          if (sync_q) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          state_q    <= ST_ACK;
          ack_q      <= 1'b1;
          hold_cnt_q <= 4'd0;
        end
        ST_ACK: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q   <= ST_WAIT_LOW;
            ack_q     <= 1'b0;
            tmo_cnt_q <= TW'(0);
          end else begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
        end
        ST_WAIT_LOW: begin
          if (!sync_q) begin
            state_q <= ST_IDLE;
          end else if (retry_s) begin
            state_q    <= ST_ACK;
            ack_q      <= 1'b1;
            hold_cnt_q <= 4'd0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags: a set event beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      overflow_q <= drop_s  | (overflow_q & ~i_clr_err);
      timeout_q  <= retry_s | (timeout_q  & ~i_clr_err);
    end
  end

  botinfo_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .wdata_i (i_botinfo),
    .pop_i   (i_pop),
    .rdata_o (o_rdata),
    .empty_o (o_empty),
    .full_o  (o_full),
    .count_o (o_count),
    .irq_o   (o_irq),
    .drop_o  (drop_s)
  );

  assign o_int_ack  = ack_q;
  assign o_overflow = overflow_q;
  assign o_timeout  = timeout_q;

endmodule
